// File: rtl/wind_vector_sched_if.sv
// Signal bundle between the wind vector scheduler, the sample source, the CORDIC engine
// and the result readback. The deadband input exists only with WINDSCHED_DEADBAND_EN.
interface wind_vector_sched_if #(
    parameter int unsigned OVR_W = 8
);
    logic                      speeden;
    logic signed [15:0]        speedX;
    logic signed [15:0]        speedY;
    logic                      cstart;
    logic signed [17:0]        cx;
    logic signed [17:0]        cy;
    logic                      cdone;
    logic        [17:0]        cmag;
    logic signed [15:0]        cang;
    logic signed [15:0]        windspeed;
    logic signed [15:0]        windangle;
    logic                      outvalid;
    logic                      busy;
    logic                      err;
    logic        [OVR_W-1:0]   overrun;
`ifdef WINDSCHED_DEADBAND_EN
    logic signed [15:0]        deadband;

    modport master (
        input  speeden, speedX, speedY, cdone, cmag, cang, deadband,
        output cstart, cx, cy, windspeed, windangle, outvalid, busy, err, overrun
    );
    modport slave (
        output speeden, speedX, speedY, cdone, cmag, cang, deadband,
        input  cstart, cx, cy, windspeed, windangle, outvalid, busy, err, overrun
    );
`else
    modport master (
        input  speeden, speedX, speedY, cdone, cmag, cang,
        output cstart, cx, cy, windspeed, windangle, outvalid, busy, err, overrun
    );
    modport slave (
        output speeden, speedX, speedY, cdone, cmag, cang,
        input  cstart, cx, cy, windspeed, windangle, outvalid, busy, err, overrun
    );
`endif
endinterface

// File: rtl/wind_vector_sched.sv
// Converts (speedX, speedY) samples to windspeed/windangle via a shared CORDIC vectoring
// engine. Optional macro WINDSCHED_DEADBAND_EN holds the angle below a speed deadband.
module wind_vector_sched #(
    parameter int unsigned CORDIC_TIMEOUT = 64,
    parameter logic [15:0] INV_GAIN       = 16'd39797,
    parameter int unsigned OVR_W          = 8
) (
    input logic                 clock,
    input logic                 reset,
    wind_vector_sched_if.master bus
);
    localparam int unsigned        CNT_W   = $clog2(CORDIC_TIMEOUT + 1);
    localparam logic signed [16:0] ANG_PI  = 17'sd23040;
    localparam logic signed [16:0] ANG_2PI = 17'sd46080;

    typedef enum logic [2:0] {IDLE, PREP, WAIT, SCALE, OUT} state_t;

    state_t                    state_q, state_d;
    logic                      cstart_q, cstart_d;
    logic signed [17:0]        cx_q, cx_d;
    logic signed [17:0]        cy_q, cy_d;
    logic                      flip_q, flip_d;
    logic                      zero_q, zero_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic        [17:0]        mag_q, mag_d;
    logic signed [15:0]        ang_q, ang_d;
    logic signed [15:0]        spd_q, spd_d;
    logic signed [15:0]        wang_q, wang_d;
    logic                      outvalid_q, outvalid_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;
    logic        [OVR_W-1:0]   ovr_q, ovr_d;
    logic                      pend_v_q, pend_v_d;
    logic signed [15:0]        pend_x_q, pend_x_d;
    logic signed [15:0]        pend_y_q, pend_y_d;

    logic                      take_live;
    logic                      take_pend;
    logic signed [15:0]        sel_x;
    logic signed [15:0]        sel_y;
    logic signed [17:0]        ext_x;
    logic signed [17:0]        ext_y;
    logic                      neg;
    logic        [17:0]        m_val;
    logic        [16:0]        spd_rnd;
    logic signed [15:0]        spd_next;
    logic signed [16:0]        ang_sum;
    logic signed [15:0]        ang_next;

    // A live sample wins over the pending one; the pending sample then waits its turn.
    assign take_live = (state_q == IDLE) && bus.speeden;
    assign take_pend = (state_q == IDLE) && !bus.speeden && pend_v_q;
    assign sel_x     = take_live ? bus.speedX : pend_x_q;
    assign sel_y     = take_live ? bus.speedY : pend_y_q;
    assign ext_x     = {{2{sel_x[15]}}, sel_x};
    assign ext_y     = {{2{sel_y[15]}}, sel_y};
    assign neg       = sel_x[15];

    // Gain correction, Q10 -> Q7 round-half-up, then saturation.
    assign m_val    = 18'((34'(mag_q) * 34'(INV_GAIN)) >> 16);
    assign spd_rnd  = 17'((19'(m_val) + 19'd4) >> 3);
    assign spd_next = spd_rnd[16] ? 16'sd32767 : signed'(spd_rnd[15:0]);

    // Undo the half-plane pre-rotation and unwrap into (-180, 180] degrees.
    assign ang_sum  = signed'({ang_q[15], ang_q}) + (flip_q ? ANG_PI : 17'sd0);
    assign ang_next = (ang_sum > ANG_PI) ? 16'(ang_sum - ANG_2PI) : 16'(ang_sum);

    always_comb begin
        state_d    = state_q;
        cstart_d   = 1'b0;
        cx_d       = cx_q;
        cy_d       = cy_q;
        flip_d     = flip_q;
        zero_d     = zero_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        ang_d      = ang_q;
        spd_d      = spd_q;
        wang_d     = wang_q;
        outvalid_d = 1'b0;
        err_d      = err_q;
        ovr_d      = ovr_q;
        pend_v_d   = pend_v_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;

        case (state_q)
            IDLE: begin
                if (take_live || take_pend) begin
                    state_d  = PREP;
                    cx_d     = neg ? -ext_x : ext_x;
                    cy_d     = neg ? -ext_y : ext_y;
                    flip_d   = neg;
                    zero_d   = (sel_x == 16'sd0) && (sel_y == 16'sd0);
                    cstart_d = !((sel_x == 16'sd0) && (sel_y == 16'sd0));
                    cnt_d    = '0;
                    if (take_pend) begin
                        pend_v_d = 1'b0;
                    end
                end
            end
            PREP: begin
                if (zero_q) begin
                    mag_d   = '0;
                    ang_d   = '0;
                    state_d = SCALE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.cdone) begin
                    mag_d   = bus.cmag;
                    ang_d   = bus.cang;
                    state_d = SCALE;
                end else if (cnt_q == CNT_W'(CORDIC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCALE: begin
                spd_d      = spd_next;
`ifdef WINDSCHED_DEADBAND_EN
                if (spd_next >= bus.deadband) begin
                    wang_d = ang_next;
                end
`else
                wang_d     = ang_next;
`endif
                outvalid_d = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Samples arriving while busy land in the one-deep buffer, newest wins.
        if ((state_q != IDLE) && bus.speeden) begin
            pend_x_d = bus.speedX;
            pend_y_d = bus.speedY;
            pend_v_d = 1'b1;
            if (pend_v_q && (ovr_q != '1)) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cstart_q   <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            flip_q     <= 1'b0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
            mag_q      <= '0;
            ang_q      <= '0;
            spd_q      <= '0;
            wang_q     <= '0;
            outvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= '0;
            pend_v_q   <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            cstart_q   <= cstart_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            flip_q     <= flip_d;
            zero_q     <= zero_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            ang_q      <= ang_d;
            spd_q      <= spd_d;
            wang_q     <= wang_d;
            outvalid_q <= outvalid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            pend_v_q   <= pend_v_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
        end
    end

    assign bus.cstart    = cstart_q;
    assign bus.cx        = cx_q;
    assign bus.cy        = cy_q;
    assign bus.windspeed = spd_q;
    assign bus.windangle = wang_q;
    assign bus.outvalid  = outvalid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: doc/wind_vector_sched.md
Name: wind_vector_sched

Overview:
Sequencer and controller that converts each (speedX, speedY) sample from the wind-direction datapath into windspeed and windangle using a shared iterative CORDIC vectoring engine. It sits between the winddirection speed outputs and the P1in/P2in readback ports. Responsibilities:
- captures samples on speeden and buffers one pending sample
- pre-rotates into the engine's convergence half-plane
- starts the engine and waits for done, with a timeout
- applies CORDIC gain correction, format conversion and angle unwrapping

Parameters:
CORDIC_TIMEOUT, 64, max cycles from cstart to cdone before abort.
INV_GAIN, 16'd39797, 1/K in Q0.16 (0.60725).
OVR_W, 8, overrun counter width.

Ports:
clock  in  1  system clock (2 MHz domain).
reset  in  1  synchronous, active-high.
speeden  in  1  one-clock pulse: speedX/speedY valid.
speedX  in  16  signed, 10 fractional bits.
speedY  in  16  signed, 10 fractional bits.
cstart  out  1  one-clock start pulse to the CORDIC engine.
cx  out  18  signed engine x input, always >= 0.
cy  out  18  signed engine y input.
cdone  in  1  one-clock engine completion pulse.
cmag  in  18  unsigned engine magnitude, 10 fractional bits, gain K included.
cang  in  16  signed engine angle in degrees, 7 fractional bits, range ±90.
windspeed  out  16  signed, 7 fractional bits, always >= 0.
windangle  out  16  signed degrees, 7 fractional bits, range (-23040, 23040].
outvalid  out  1  one-clock pulse: new windspeed/windangle.
busy  out  1  high in any state other than IDLE.
err  out  1  sticky timeout flag; cleared only by reset.
overrun  out  OVR_W  saturating count of dropped samples.

Behaviour:
- Clocking and reset: single clock, clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state = IDLE; pending buffer empty.
- Reset mid-operation: returns to IDLE on the next edge. A cdone arriving afterwards is ignored.
- States: IDLE, PREP, WAIT, SCALE, OUT.
- IDLE: on speeden, or if the pending buffer is valid, latch the sample and go to PREP. A live speeden takes priority; the pending sample then stays pending.
- PREP (1 cycle):
  - if x < 0, drive cx = -x and cy = -y (sign-extended to 18 bits, so -32768 negates correctly) and set flip = 1
  - otherwise drive cx = x, cy = y, flip = 0
  - if x == 0 and y == 0, bypass the engine: go to SCALE with cmag/cang forced to 0
  - otherwise assert cstart for this cycle only and go to WAIT
- WAIT:
  - on cdone, register cmag and cang and go to SCALE
  - if a cycle counter reaches CORDIC_TIMEOUT first, set err and go to IDLE with no outvalid
- SCALE (1 cycle):
  - speed: m = (cmag * INV_GAIN) >> 16; windspeed_next = (m + 4) >> 3 (round-half-up, 10 to 7 fractional bits); saturate to 32767
  - angle: a = cang + (flip ? 23040 : 0); if a > 23040, subtract 46080
- OUT (1 cycle): register windspeed and windangle, pulse outvalid, go to IDLE. Outputs hold until the next OUT.
- Latency: speeden at edge k gives cstart during cycle k+1. If cdone arrives at edge k+1+L, outvalid is high in cycle k+L+3. The zero-vector bypass gives outvalid in cycle k+3.
- Pending buffer (depth 1):
  - speeden while busy with the buffer empty: store the sample
  - speeden while busy with the buffer full: overwrite with the newest sample and increment overrun (saturates at all-ones)
  - speeden in the same cycle the buffer is consumed: the new sample is stored, no overrun
- cdone outside WAIT is ignored. cstart is never re-asserted while in WAIT.

Optional Feature:
WINDSCHED_DEADBAND_EN
- Defined: adds input port deadband (16 bits, 7 fractional bits). When windspeed_next < deadband, windangle holds its previous value; windspeed still updates and outvalid still pulses.
- Undefined: no deadband port; windangle always updates.

Test Plan:
- speedX = 1024, speedY = 0, behavioural CORDIC with L = 20 -> cx = 1024, cy = 0; outvalid 23 cycles after speeden; windspeed = 128, windangle = 0.
- speedX = -1024, speedY = 0 -> cx = 1024, cy = 0, flip = 1; windspeed = 128, windangle = 23040.
- speedX = 0, speedY = 1024 -> windangle = 11520; speedX = 0, speedY = -1024 -> windangle = -11520.
- speedX = speedY = 0 -> no cstart; outvalid 3 cycles after speeden; windspeed = 0, windangle = 0.
- Three speeden pulses 2 cycles apart with L = 20 -> two outvalid pulses (samples 1 and 3), overrun = 1.
- cdone held low -> err = 1 after 64 WAIT cycles, no outvalid, busy = 0; reset in WAIT then late cdone -> no outvalid, all outputs 0.
